// File: rtl/ws2812_pkg.sv
// ws2812_pkg: FSM state encoding and GRB word layout shared by the WS2812 driver.
package ws2812_pkg;

    typedef enum logic [1:0] {LATCH, IDLE, SEND} state_e;

    localparam int WORD_W = 24;
    localparam int G_MSB  = 23;
    localparam int R_MSB  = 15;
    localparam int B_MSB  = 7;

endpackage

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: pulse-width codes one bit per start strobe into a registered line level.
module ws2812_bit_timer #(
    parameter int T0H_CYCLES  = 8,
    parameter int T1H_CYCLES  = 16,
    parameter int TBIT_CYCLES = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic bit_i,
    output logic line_o,
    output logic bit_done_o
);

    localparam int CW = $clog2(TBIT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          line_q, line_d;

    assign bit_done_o = run_q && cnt_q == CW'(TBIT_CYCLES - 1);
    assign line_o     = line_q;

    // Every bit begins high, so start drives the line up on the accepting edge itself.
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        run_d  = run_q;
        line_d = run_q && (cnt_d < (bit_i ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES)));
        if (start_i) begin
            cnt_d  = '0;
            run_d  = 1'b1;
            line_d = 1'b1;
        end else if (bit_done_o || !run_q) begin
            cnt_d  = '0;
            run_d  = 1'b0;
            line_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            line_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/ws2812_driver.sv
// ws2812_driver: sends a captured GRB word to a WS2812 chain, then holds the latch period.
// WS2812_AUTO_REFRESH_EN: when defined, frames restart automatically after each one-cycle idle.
module ws2812_driver import ws2812_pkg::*; #(
    parameter int NUM_LEDS     = 1,
    parameter int T0H_CYCLES   = 8,
    parameter int T1H_CYCLES   = 16,
    parameter int TBIT_CYCLES  = 25,
    parameter int RESET_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] level_r,
    input  logic [7:0] level_g,
    input  logic [7:0] level_b,
    input  logic       valid,
    output logic       ready,
    output logic       data_out
);

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < TBIT_CYCLES &&
          RESET_CYCLES >= 1 && NUM_LEDS >= 1)) begin : g_bad_params
        $error("ws2812_driver: invalid timing or chain parameters");
    end

    localparam int PW = $clog2(WORD_W);
    localparam int LW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
    localparam int RW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [LW-1:0]       led_q, led_d;
    logic [RW-1:0]       lat_q, lat_d;
    logic                start, bit_done, go, last_ptr, last_led;

`ifdef WS2812_AUTO_REFRESH_EN
    assign go = 1'b1;
`else
    assign go = valid;
`endif

    assign ready    = state_q == IDLE;
    assign last_ptr = ptr_q == PW'(WORD_W - 1);
    assign last_led = led_q == LW'(NUM_LEDS - 1);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ptr_d   = ptr_q;
        led_d   = led_q;
        lat_d   = lat_q;
        start   = 1'b0;
        case (state_q)
            LATCH: begin
                lat_d = lat_q + RW'(1);
                if (lat_q == RW'(RESET_CYCLES - 1)) begin
                    lat_d   = '0;
                    state_d = IDLE;
                end
            end
            IDLE: if (go) begin
                word_d[G_MSB -: 8] = level_g;
                word_d[R_MSB -: 8] = level_r;
                word_d[B_MSB -: 8] = level_b;
                ptr_d   = '0;
                led_d   = '0;
                start   = 1'b1;
                state_d = SEND;
            end
            SEND: if (bit_done) begin
                // The pointer wraps to G[7] so the same word feeds every LED.
                ptr_d = last_ptr ? '0 : ptr_q + PW'(1);
                led_d = last_ptr ? led_q + LW'(1) : led_q;
                if (last_ptr && last_led) begin
                    led_d   = '0;
                    state_d = LATCH;
                end else begin
                    start = 1'b1;
                end
            end
            default: state_d = LATCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LATCH;
            word_q  <= '0;
            ptr_q   <= '0;
            led_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            ptr_q   <= ptr_d;
            led_q   <= led_d;
            lat_q   <= lat_d;
        end
    end

    ws2812_bit_timer #(
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES),
        .TBIT_CYCLES(TBIT_CYCLES)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start),
        .bit_i     (word_q[PW'(WORD_W - 1) - ptr_q]),
        .line_o    (data_out),
        .bit_done_o(bit_done)
    );

endmodule

// File: tb/tb_ws2812_driver.sv
// tb_ws2812_driver: random and directed stimulus on 1-LED and 3-LED chains, scored per cycle against a waveform model.
module tb_ws2812_driver;

    localparam int T0H  = 2;
    localparam int T1H  = 4;
    localparam int TBIT = 6;
    localparam int RST  = 10;
`ifdef WS2812_AUTO_REFRESH_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] lr = '0, lg = '0, lb = '0;
    logic [1:0] valid = '0;
    logic [1:0] ready, dout;

    int checks = 0;
    int errors = 0;
    bit q [2][$];
    int rcnt [2];

    always #5 clk = ~clk;

    ws2812_driver #(.NUM_LEDS(1), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .TBIT_CYCLES(TBIT), .RESET_CYCLES(RST)) dut1 (
        .clk(clk), .reset(reset), .level_r(lr), .level_g(lg), .level_b(lb),
        .valid(valid[0]), .ready(ready[0]), .data_out(dout[0])
    );

    ws2812_driver #(.NUM_LEDS(3), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .TBIT_CYCLES(TBIT), .RESET_CYCLES(RST)) dut3 (
        .clk(clk), .reset(reset), .level_r(lr), .level_g(lg), .level_b(lb),
        .valid(valid[1]), .ready(ready[1]), .data_out(dout[1])
    );

    task automatic chk(input string name, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s chain%0d t=%0t got %b want %b", name, i, $time, act, exp);
        end
    endtask

    // Monitor: each accepted frame expands into its full expected line waveform.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit        e;
            bit [23:0] w;
            int        n;
            n = (i == 0) ? 1 : 3;
            if (!reset) begin
                chk("reset_line", i, dout[i], 1'b0);
                chk("reset_ready", i, ready[i], 1'b0);
                q[i].delete();
                rcnt[i] = RST + 1;
            end else begin
                if (rcnt[i] > 0) rcnt[i]--;
                e = q[i].size() > 0 ? q[i].pop_front() : 1'b0;
                chk("line", i, dout[i], e);
                chk("ready", i, ready[i], rcnt[i] == 0);
                if (rcnt[i] == 0 && (AUTO || valid[i])) begin
                    w = {lg, lr, lb};
                    for (int k = 0; k < 24 * n * TBIT; k++)
                        q[i].push_back((k % TBIT) < (w[23 - (k / TBIT) % 24] ? T1H : T0H));
                    rcnt[i] = 24 * n * TBIT + RST + 1;
                end
            end
        end
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (14) @(posedge clk);
        #1 lg = 8'h00; lr = 8'hFF; lb = 8'h81; valid = 2'b11;
        @(posedge clk);
        #1 valid = 2'b00;
        repeat (450) @(posedge clk);
        #1 valid = 2'b11;
        repeat (50) @(posedge clk);
        #1 lg = 8'hAA; lr = 8'hAA; lb = 8'hAA;
        repeat (1000) @(posedge clk);
        #1 valid = 2'b00;
        repeat (460) @(posedge clk);
        #1 lg = 8'h5C; valid = 2'b11;
        @(posedge clk);
        #1 valid = 2'b00;
        repeat (62) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);
        repeat (3000) begin
            @(posedge clk);
            #1 valid = 2'($urandom);
            if ($urandom_range(7) == 0) {lg, lr, lb} = 24'($urandom);
            reset = reset ? ($urandom_range(599) != 0) : ($urandom_range(2) == 0);
        end
        @(posedge clk);
        #1 reset = 1'b1; valid = 2'b00;
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_driver.md
# ws2812_driver

Serial LED output stage that sits downstream of the three encoder-driven channel levels. It drives a WS2812-style single-wire LED chain instead of three PWM pins. On a valid/ready handshake it captures the red, green and blue 8-bit levels and shifts them out as a GRB, MSB-first pulse-width-coded frame, repeated once per LED in the chain. It then holds the line low for the latch period.

## Interface

Parameters:
- NUM_LEDS, 1: number of LEDs in the chain; each receives the same colour.
- T0H_CYCLES, 8: high time of a 0 bit, in clk cycles.
- T1H_CYCLES, 16: high time of a 1 bit, in clk cycles.
- TBIT_CYCLES, 25: total period of one bit, in clk cycles.
- RESET_CYCLES, 1000: low latch time after a frame, in clk cycles.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- level_r  in  8  red level.
- level_g  in  8  green level.
- level_b  in  8  blue level.
- valid  in  1  request to send the current levels.
- ready  out  1  block idle; a request is accepted on a rising clk edge where valid && ready.
- data_out  out  1  serial line to the first LED.

## Operation

- States:
  - LATCH: data_out is 0 and ready is 0. Counts RESET_CYCLES cycles, then goes to IDLE.
  - IDLE: ready is 1 and data_out is 0. On valid, captures {level_g, level_r, level_b} into a 24-bit shift register and goes to SEND.
  - SEND: transmits 24*NUM_LEDS bits. After the last bit, goes to LATCH.
- Reset (assertion or mid-operation): state goes to LATCH, data_out is forced to 0 immediately and asynchronously, ready is 0, and all counters clear. The first ready therefore arrives only after a full latch period.
- Bit encoding: each bit occupies exactly TBIT_CYCLES cycles. It is high for T1H_CYCLES if the bit is 1, or T0H_CYCLES if it is 0, and low for the remainder.
- Bit order per LED: G[7]..G[0], R[7]..R[0], B[7]..B[0].
- The captured word is reused for every LED. The LED counter wraps the 24-bit pointer back to G[7].
- Inputs change freely while ready is 0. They are ignored, and the captured word is unaffected.
- Elaboration must fail unless 0 < T0H_CYCLES < T1H_CYCLES < TBIT_CYCLES, RESET_CYCLES >= 1 and NUM_LEDS >= 1.
- Counter widths are derived with $clog2 from the parameters.

## Timing

- data_out is a registered output, so there are no glitches.
- Handshake to first edge: on the accepting edge, data_out is set to 1. The first high cycle is the cycle immediately after acceptance.
- Bit boundaries are continuous, with no idle cycle between bits or between LEDs.
- Busy time: from the accepting edge to ready high is exactly 24*NUM_LEDS*TBIT_CYCLES + RESET_CYCLES cycles.
- ready drops in the cycle after acceptance.
- After reset deassertion, ready rises after exactly RESET_CYCLES cycles.

## Configuration

- WS2812_AUTO_REFRESH_EN:
  - Defined: valid is ignored. IDLE lasts one cycle with ready=1, then a new frame starts automatically, capturing the levels present on that cycle. The result is continuous frames separated by exactly RESET_CYCLES low cycles plus one idle cycle.
  - Undefined: frames are sent only on the handshake.

## Structure

- ws2812_pkg contains:
  - state enum (LATCH, IDLE, SEND)
  - the colour-order bit-position constants
  - the 24-bit word width constant
- Sub-module ws2812_bit_timer holds the per-bit cycle counter.
  - Inputs: start and the bit value.
  - Outputs: the line level and a bit_done strobe on the last cycle of the bit.
- The top level holds the FSM, shift pointer, LED counter and latch counter.

## Test plan

All scenarios use T0H=2, T1H=4, TBIT=6, RESET=10 unless noted.

- Reset release: ready rises exactly 10 cycles after reset deasserts, and data_out stays 0 throughout.
- NUM_LEDS=1, G=0x00, R=0xFF, B=0x81, valid pulsed:
  - 24 high pulses with widths 2×8, then 4×8, then 4,2,2,2,2,2,2,4.
  - Each pulse starts every 6 cycles, and the first starts the cycle after acceptance.
- NUM_LEDS=3, same levels: 72 pulses forming three identical 24-pulse patterns. ready returns 442 cycles after acceptance.
- valid held high and levels changed to 0xAA mid-frame: the transmitted pattern is unchanged. The second frame starts only after ready and carries the new values.
- Reset asserted during bit 10: data_out goes to 0 the same cycle and ready goes to 0. ready returns 10 cycles after release, and no partial frame resumes.
- WS2812_AUTO_REFRESH_EN defined, valid held 0:
  - Frames repeat back to back, with data_out low for 11 cycles between them.
  - A level change made during a frame appears in the next frame.
